pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencing controller for a row of PEs sharing one broadcast buffer and one psum drain path. For each layer it configures the mode and gates ifmap/filter broadcast until every PE scratch pad is full. It then runs convolution until every PE reports done, waits for the psum drain, and repeats via `conv_continue` for a programmed number of rounds. It sits between the global buffer/top-level sequencer and the PE row.

## Interface
Parameters:
- `NUM_PE`, 6: number of PEs controlled (bit-vector width of status inputs)
- `ROUND_W`, 8: width of round counter / `cfg_rounds`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a layer; sampled only in IDLE
- `cfg_mode`  in  OP_MODE  mode for this layer; captured on accepted `start`
- `cfg_rounds`  in  ROUND_W  convolution rounds; captured on accepted `start`; 0 treated as 1
- `buf_valid`  in  1  buffer has a packet on the broadcast bus
- `buf_ready`  out  1  broadcast permitted this cycle
- `pe_full`  in  NUM_PE  per-PE ifmap scratch pad full
- `pe_conv_done`  in  NUM_PE  per-PE convolution done
- `pe_error`  in  NUM_PE  per-PE overflow error
- `psum_drain_done`  in  1  single-cycle pulse: psum collector finished this round
- `pe_mode`  out  OP_MODE  registered mode to all PEs
- `change_mode`  out  1  one-cycle pulse to all PEs
- `op_stage`  out  OP_STAGE  stage broadcast to all PEs
- `conv_continue`  out  1  one-cycle pulse: reload ifmap, next round
- `busy`  out  1  high in any state except IDLE
- `layer_done`  out  1  one-cycle pulse at end of layer
- `round_idx`  out  ROUND_W  current round, 0-based
- `error`  out  1  sticky error flag

## Operation
- States: IDLE, CFG, LOAD, CONV, DRAIN, NEXT, DONE, ERR.
- IDLE: `start` captures config, clears `round_idx`, -> CFG. `start` in any other state is ignored.
- CFG, one cycle: `pe_mode` <= captured mode, `change_mode`=1, -> LOAD.
- LOAD: `op_stage`=LOAD. `buf_ready` = ~&`pe_full` (combinational). A packet transfers when `buf_valid`&`buf_ready`. When &`pe_full`, -> CONV.
- CONV: `op_stage`=CONV, `buf_ready`=0. When &`pe_conv_done`, -> DRAIN.
- DRAIN: `op_stage`=DRAIN. On `psum_drain_done`: if `round_idx`==rounds-1, -> DONE; else -> NEXT.
- NEXT, one cycle: `conv_continue`=1, `round_idx`++, -> LOAD.
- DONE, one cycle: `layer_done`=1, -> IDLE.
- ERR: entered from any state except IDLE when |`pe_error`. `error`=1, `op_stage`=IDLE, `buf_ready`=0. Held until `rst`. `pe_error` in IDLE also sets `error` and enters ERR. Error takes priority over every other transition in the same cycle.
- Rounds: a captured `cfg_rounds` of 0 is stored as 1. `round_idx` never exceeds rounds-1.

## Timing
- Reset values: state IDLE, `pe_mode`=MODE_DEFAULT, `op_stage`=STAGE_IDLE, `change_mode`=0, `conv_continue`=0, `buf_ready`=0, `busy`=0, `layer_done`=0, `round_idx`=0, `error`=0.
- `rst` mid-layer returns to IDLE on the next edge. No pulse is emitted on that edge.
- All outputs are registered except `buf_ready`, which is a function of the state register and `pe_full`.
- `start` at edge T: CFG at T+1, with `change_mode` high that cycle. LOAD at T+2.
- &`pe_full` sampled at edge T in LOAD: CONV from T+1, and `buf_ready` is already low in cycle T.
- `pe_full` falling during LOAD after having been all-high is impossible: the transition happens on first all-high.
- `pe_conv_done` and `psum_drain_done` asserted simultaneously: only the conv condition is consumed. The drain pulse is lost, and the top-level must not pulse drain before entering DRAIN.
- Minimum per-round overhead: 1 cycle NEXT + LOAD.

## Structure
- Shared package (`sys_types` or equivalent) holds `OP_MODE`, `OP_STAGE` (STAGE_IDLE, STAGE_LOAD, STAGE_CONV, STAGE_DRAIN), MODE_DEFAULT, and the controller state enum.
- Single module. The round counter lives inline; no sub-module is warranted.

## Test plan
- Single round, NUM_PE=6, `cfg_rounds`=1: `start`; raise `pe_full` bits one per cycle -> `buf_ready` drops the cycle all six are high. Raise all `pe_conv_done`, then pulse `psum_drain_done` -> `layer_done` pulses exactly once, `conv_continue` is never asserted, `busy` returns to 0.
- Three rounds: `cfg_rounds`=3 -> exactly 2 `conv_continue` pulses, `round_idx` sequence 0,1,2, then one `layer_done`.
- `cfg_rounds`=0 -> behaves identically to 1.
- Error mid-CONV: pulse `pe_error[3]` -> next cycle `error`=1, `op_stage`=STAGE_IDLE, `buf_ready`=0. `start` is ignored; only `rst` clears.
- Reset during DRAIN of round 1 of 4 -> IDLE with all reset values. A new `start` with mode B -> `change_mode` pulse with `pe_mode`=B and `round_idx`=0.
- `start` while busy, plus partial `pe_conv_done` (5 of 6 bits) -> no state change, stays in CONV.

Source files
------------

// File: rtl/pe_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_ctrl_pkg
// Description : Shared types for the PE-row sequencing controller: PE
//               operating modes, stage broadcast codes, controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_array_ctrl_pkg;

    localparam int c_mode_w  = 2;
    localparam int c_stage_w = 2;
    localparam int c_state_w = 3;

    typedef enum logic [c_mode_w-1:0] {
        MODE_DEFAULT = 2'd0,
        MODE_CONV    = 2'd1,
        MODE_FC      = 2'd2,
        MODE_POOL    = 2'd3
    } op_mode_t;

    typedef enum logic [c_stage_w-1:0] {
        STAGE_IDLE  = 2'd0,
        STAGE_LOAD  = 2'd1,
        STAGE_CONV  = 2'd2,
        STAGE_DRAIN = 2'd3
    } op_stage_t;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CONV  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } ctrl_state_t;

    // Stage code seen by the PEs; bookkeeping states present as idle.
    function automatic op_stage_t stage_of(ctrl_state_t s);
        case (s)
            ST_LOAD:  return STAGE_LOAD;
            ST_CONV:  return STAGE_CONV;
            ST_DRAIN: return STAGE_DRAIN;
            default:  return STAGE_IDLE;
        endcase
    endfunction

endpackage : pe_array_ctrl_pkg
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_ctrl
// Description : Per-layer sequencer for a PE row: mode config, broadcast
//               load gating, convolution, psum drain and multi-round repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int NUM_PE  = 6,
    parameter int ROUND_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  op_mode_t           cfg_mode,
    input  logic [ROUND_W-1:0] cfg_rounds,
    input  logic               buf_valid,
    output logic               buf_ready,
    input  logic [NUM_PE-1:0]  pe_full,
    input  logic [NUM_PE-1:0]  pe_conv_done,
    input  logic [NUM_PE-1:0]  pe_error,
    input  logic               psum_drain_done,
    output op_mode_t           pe_mode,
    output logic               change_mode,
    output op_stage_t          op_stage,
    output logic               conv_continue,
    output logic               busy,
    output logic               layer_done,
    output logic [ROUND_W-1:0] round_idx,
    output logic               error
);

    ctrl_state_t        r_state_q,         w_state_d;
    op_mode_t           r_pe_mode_q,       w_pe_mode_d;
    op_stage_t          r_op_stage_q,      w_op_stage_d;
    logic [ROUND_W-1:0] r_rounds_q,        w_rounds_d;
    logic [ROUND_W-1:0] r_round_idx_q,     w_round_idx_d;
    logic               r_change_mode_q,   w_change_mode_d;
    logic               r_conv_continue_q, w_conv_continue_d;
    logic               r_busy_q,          w_busy_d;
    logic               r_layer_done_q,    w_layer_done_d;
    logic               r_error_q,         w_error_d;

    logic w_all_full;
    logic w_all_done;
    logic w_any_err;
    logic w_last_round;

    assign w_all_full   = &pe_full;
    assign w_all_done   = &pe_conv_done;
    assign w_any_err    = |pe_error;
    assign w_last_round = (r_round_idx_q == (r_rounds_q - ROUND_W'(1)));

    // The broadcast gate closes in the same cycle the last scratch pad fills.
    assign buf_ready = (r_state_q == ST_LOAD) && !w_all_full;

    always_comb begin
        w_state_d     = r_state_q;
        w_pe_mode_d   = r_pe_mode_q;
        w_rounds_d    = r_rounds_q;
        w_round_idx_d = r_round_idx_q;
        w_error_d     = r_error_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_pe_mode_d   = cfg_mode;
                    w_rounds_d    = (cfg_rounds == '0) ? ROUND_W'(1) : cfg_rounds;
                    w_round_idx_d = '0;
                    w_state_d     = ST_CFG;
                end
            end
            ST_CFG:   w_state_d = ST_LOAD;
            ST_LOAD:  if (w_all_full) w_state_d = ST_CONV;
            ST_CONV:  if (w_all_done) w_state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (psum_drain_done) begin
                    w_state_d = w_last_round ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_round_idx_d = r_round_idx_q + ROUND_W'(1);
                w_state_d     = ST_LOAD;
            end
            ST_DONE:  w_state_d = ST_IDLE;
            ST_ERR:   w_state_d = ST_ERR;
            default:  w_state_d = ST_IDLE;
        endcase

        // An error overrides any progress made this cycle.
        if (w_any_err) begin
            w_state_d     = ST_ERR;
            w_error_d     = 1'b1;
            w_pe_mode_d   = r_pe_mode_q;
            w_rounds_d    = r_rounds_q;
            w_round_idx_d = r_round_idx_q;
        end

        w_op_stage_d      = stage_of(w_state_d);
        w_change_mode_d   = (w_state_d == ST_CFG);
        w_conv_continue_d = (w_state_d == ST_NEXT);
        w_layer_done_d    = (w_state_d == ST_DONE);
        w_busy_d          = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q         <= ST_IDLE;
            r_pe_mode_q       <= MODE_DEFAULT;
            r_op_stage_q      <= STAGE_IDLE;
            r_rounds_q        <= ROUND_W'(1);
            r_round_idx_q     <= '0;
            r_change_mode_q   <= 1'b0;
            r_conv_continue_q <= 1'b0;
            r_busy_q          <= 1'b0;
            r_layer_done_q    <= 1'b0;
            r_error_q         <= 1'b0;
        end else begin
            r_state_q         <= w_state_d;
            r_pe_mode_q       <= w_pe_mode_d;
            r_op_stage_q      <= w_op_stage_d;
            r_rounds_q        <= w_rounds_d;
            r_round_idx_q     <= w_round_idx_d;
            r_change_mode_q   <= w_change_mode_d;
            r_conv_continue_q <= w_conv_continue_d;
            r_busy_q          <= w_busy_d;
            r_layer_done_q    <= w_layer_done_d;
            r_error_q         <= w_error_d;
        end
    end

    assign pe_mode       = r_pe_mode_q;
    assign op_stage      = r_op_stage_q;
    assign round_idx     = r_round_idx_q;
    assign change_mode   = r_change_mode_q;
    assign conv_continue = r_conv_continue_q;
    assign busy          = r_busy_q;
    assign layer_done    = r_layer_done_q;
    assign error         = r_error_q;

    // Packet handshake is observed by the buffer and PEs, not by the sequencer.
    logic w_unused;
    assign w_unused = buf_valid;

endmodule : pe_array_ctrl
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_ctrl
// Description : Self-checking bench for pe_array_ctrl with a reactive random
//               PE-row model and a layer-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_ctrl;
    import pe_array_ctrl_pkg::*;

    localparam int NUM_PE  = 6;
    localparam int ROUND_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    op_mode_t           cfg_mode = MODE_DEFAULT;
    logic [ROUND_W-1:0] cfg_rounds = '0;
    logic               buf_valid = 1'b0;
    logic               buf_ready;
    logic [NUM_PE-1:0]  pe_full = '0;
    logic [NUM_PE-1:0]  pe_conv_done = '0;
    logic [NUM_PE-1:0]  pe_error = '0;
    logic               psum_drain_done = 1'b0;
    op_mode_t           pe_mode;
    logic               change_mode;
    op_stage_t          op_stage;
    logic               conv_continue;
    logic               busy;
    logic               layer_done;
    logic [ROUND_W-1:0] round_idx;
    logic               error;

    int checks = 0;
    int failures = 0;

    // Cumulative observations; tests take snapshots and compare deltas.
    int        n_cc = 0, n_ld = 0, n_cm = 0, n_br_bad = 0;
    int        rq[$];
    op_stage_t prev_stage = STAGE_IDLE;

    pe_array_ctrl #(.NUM_PE(NUM_PE), .ROUND_W(ROUND_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_rounds(cfg_rounds), .buf_valid(buf_valid), .buf_ready(buf_ready),
        .pe_full(pe_full), .pe_conv_done(pe_conv_done), .pe_error(pe_error),
        .psum_drain_done(psum_drain_done), .pe_mode(pe_mode),
        .change_mode(change_mode), .op_stage(op_stage),
        .conv_continue(conv_continue), .busy(busy), .layer_done(layer_done),
        .round_idx(round_idx), .error(error)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #2;
        if (buf_ready !== ((op_stage == STAGE_LOAD) && !(&pe_full))) n_br_bad++;
        if (conv_continue === 1'b1) n_cc++;
        if (layer_done === 1'b1)    n_ld++;
        if (change_mode === 1'b1)   n_cm++;
        if (op_stage == STAGE_CONV && prev_stage != STAGE_CONV) rq.push_back(int'(round_idx));
        prev_stage = op_stage;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic int pick_zero(logic [NUM_PE-1:0] v);
        int k = $urandom_range(0, NUM_PE-1);
        for (int i = 0; i < NUM_PE; i++) begin
            if (!v[(k+i)%NUM_PE]) return (k+i)%NUM_PE;
        end
        return 0;
    endfunction

    // Returns in the CFG cycle following the accepted start.
    task automatic start_layer(input op_mode_t m, input int r);
        cyc();
        start = 1'b1; cfg_mode = m; cfg_rounds = ROUND_W'(r);
        cyc();
        start = 1'b0;
    endtask

    // Reactive PE row + psum collector; runs until the layer finishes or a stop point.
    task automatic drive_layer(input int max_cycles, input bit stop_en, input op_stage_t stop_stage,
                               input int stop_round, output bit timed_out);
        bit drained = 1'b0;
        timed_out = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            cyc();
            psum_drain_done = 1'b0;
            if (stop_en && op_stage == stop_stage && int'(round_idx) == stop_round) return;
            if (!busy) return;
            buf_valid = 1'($urandom_range(0, 1));
            case (op_stage)
                STAGE_LOAD: begin
                    pe_conv_done = '0;
                    if (!(&pe_full) && $urandom_range(0, 3) != 0) pe_full[pick_zero(pe_full)] = 1'b1;
                end
                STAGE_CONV: if ($urandom_range(0, 2) != 0) pe_conv_done[$urandom_range(0, NUM_PE-1)] = 1'b1;
                STAGE_DRAIN: begin
                    pe_full = '0; pe_conv_done = '0;
                    if (!drained && $urandom_range(0, 2) == 0) begin
                        psum_drain_done = 1'b1; drained = 1'b1;
                    end
                end
                default: ;
            endcase
            if (op_stage != STAGE_DRAIN) drained = 1'b0;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst = 1'b1;
        repeat (3) cyc();
        obs = {busy, change_mode, conv_continue, layer_done, error, buf_ready, op_stage, pe_mode, round_idx};
        checks++;
        if (obs !== 18'd0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || op_stage !== STAGE_IDLE) begin
            failures++; $display("FAIL reset_idle: busy=%b stage=%0d want 0/0", busy, op_stage);
        end
    endtask

    task automatic test_single_round();
        int ld0 = n_ld, cc0 = n_cc, br0 = n_br_bad, qb;
        bit to;
        pe_full = '0; pe_conv_done = '0;
        start_layer(MODE_CONV, 1);
        checks++;
        if (change_mode !== 1'b1 || pe_mode !== MODE_CONV) begin
            failures++; $display("FAIL single_cfg: cm=%b mode=%0d want 1/%0d", change_mode, pe_mode, MODE_CONV);
        end
        cyc();
        checks++;
        if (op_stage !== STAGE_LOAD || busy !== 1'b1 || change_mode !== 1'b0) begin
            failures++; $display("FAIL single_load: stage=%0d busy=%b cm=%b want LOAD/1/0", op_stage, busy, change_mode);
        end
        qb = rq.size();
        for (int i = 0; i < NUM_PE; i++) begin
            cyc();
            pe_full[i] = 1'b1;
            #1;
            checks++;
            if (buf_ready !== (i != NUM_PE-1)) begin
                failures++; $display("FAIL single_buf_ready[%0d]: got %b want %b", i, buf_ready, i != NUM_PE-1);
            end
        end
        cyc();
        checks++;
        if (op_stage !== STAGE_CONV) begin
            failures++; $display("FAIL single_conv: stage=%0d want %0d", op_stage, STAGE_CONV);
        end
        drive_layer(500, 1'b0, STAGE_IDLE, 0, to);
        checks++;
        if (to || busy !== 1'b0 || n_ld - ld0 != 1 || n_cc - cc0 != 0) begin
            failures++; $display("FAIL single_end: to=%b busy=%b ld=%0d cc=%0d want 0/0/1/0", to, busy, n_ld-ld0, n_cc-cc0);
        end
        checks++;
        if (rq.size() - qb != 1 || n_br_bad != br0) begin
            failures++; $display("FAIL single_trace: rounds=%0d br_bad=%0d want 1/0", rq.size()-qb, n_br_bad-br0);
        end
    endtask

    // Layer-level model: max(cfg,1) rounds, one conv_continue between rounds, one layer_done.
    task automatic test_rounds(input int cfg, input op_mode_t m);
        int eff = (cfg == 0) ? 1 : cfg;
        int ld0 = n_ld, cc0 = n_cc, cm0 = n_cm, br0 = n_br_bad, qb = rq.size();
        bit to;
        pe_full = '0; pe_conv_done = '0;
        start_layer(m, cfg);
        checks++;
        if (change_mode !== 1'b1 || pe_mode !== m || round_idx !== '0) begin
            failures++; $display("FAIL rounds%0d_cfg: cm=%b mode=%0d idx=%0d want 1/%0d/0", cfg, change_mode, pe_mode, round_idx, m);
        end
        drive_layer(4000, 1'b0, STAGE_IDLE, 0, to);
        checks++;
        if (to || busy !== 1'b0) begin
            failures++; $display("FAIL rounds%0d_finish: to=%b busy=%b want 0/0", cfg, to, busy);
        end
        checks++;
        if (n_cc - cc0 != eff - 1 || n_ld - ld0 != 1 || n_cm - cm0 != 1) begin
            failures++; $display("FAIL rounds%0d_pulses: cc=%0d ld=%0d cm=%0d want %0d/1/1", cfg, n_cc-cc0, n_ld-ld0, n_cm-cm0, eff-1);
        end
        checks++;
        if (rq.size() - qb != eff || n_br_bad != br0) begin
            failures++; $display("FAIL rounds%0d_trace: rounds=%0d br_bad=%0d want %0d/0", cfg, rq.size()-qb, n_br_bad-br0, eff);
        end else begin
            for (int k = 0; k < eff; k++) begin
                checks++;
                if (rq[qb+k] != k) begin
                    failures++; $display("FAIL rounds%0d_idx[%0d]: got %0d want %0d", cfg, k, rq[qb+k], k);
                end
            end
        end
    endtask

    task automatic test_multi_round();  test_rounds(3, MODE_FC);      endtask
    task automatic test_zero_rounds();  test_rounds(0, MODE_POOL);    endtask

    task automatic test_random_layers();
        for (int it = 0; it < 6; it++) begin
            test_rounds(int'($urandom_range(0, 5)), op_mode_t'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_error_conv();
        int cm0;
        bit to;
        pe_full = '0; pe_conv_done = '0;
        start_layer(MODE_CONV, 2);
        drive_layer(500, 1'b1, STAGE_CONV, 0, to);
        checks++;
        if (to || op_stage !== STAGE_CONV) begin
            failures++; $display("FAIL err_reach_conv: to=%b stage=%0d want 0/%0d", to, op_stage, STAGE_CONV);
        end
        pe_error = 6'b001000;
        cyc();
        pe_error = '0;
        pe_full = '0;
        #1;
        checks++;
        if (error !== 1'b1 || op_stage !== STAGE_IDLE || buf_ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL err_enter: err=%b stage=%0d br=%b busy=%b want 1/0/0/1", error, op_stage, buf_ready, busy);
        end
        cm0 = n_cm;
        start = 1'b1;
        repeat (4) cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (error !== 1'b1 || op_stage !== STAGE_IDLE || n_cm != cm0) begin
            failures++; $display("FAIL err_sticky: err=%b stage=%0d cm=%0d want 1/0/0", error, op_stage, n_cm-cm0);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL err_clear: err=%b busy=%b want 0/0", error, busy);
        end
    endtask

    task automatic test_reset_in_drain();
        int ld0, cc0;
        logic [17:0] obs;
        bit to;
        pe_full = '0; pe_conv_done = '0;
        start_layer(MODE_FC, 4);
        drive_layer(2000, 1'b1, STAGE_DRAIN, 1, to);
        checks++;
        if (to || op_stage !== STAGE_DRAIN || round_idx !== 8'd1) begin
            failures++; $display("FAIL rst_reach_drain: to=%b stage=%0d idx=%0d want 0/%0d/1", to, op_stage, round_idx, STAGE_DRAIN);
        end
        ld0 = n_ld; cc0 = n_cc;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pe_full = '0; pe_conv_done = '0;
        obs = {busy, change_mode, conv_continue, layer_done, error, buf_ready, op_stage, pe_mode, round_idx};
        checks++;
        if (obs !== 18'd0 || n_ld != ld0 || n_cc != cc0) begin
            failures++; $display("FAIL rst_mid_layer: got %h ld=%0d cc=%0d want 0/0/0", obs, n_ld-ld0, n_cc-cc0);
        end
        start_layer(MODE_POOL, 2);
        checks++;
        if (change_mode !== 1'b1 || pe_mode !== MODE_POOL || round_idx !== '0) begin
            failures++; $display("FAIL rst_restart: cm=%b mode=%0d idx=%0d want 1/%0d/0", change_mode, pe_mode, round_idx, MODE_POOL);
        end
        drive_layer(2000, 1'b0, STAGE_IDLE, 0, to);
        checks++;
        if (to || busy !== 1'b0) begin
            failures++; $display("FAIL rst_restart_finish: to=%b busy=%b want 0/0", to, busy);
        end
    endtask

    task automatic test_start_while_busy();
        int cm0, ld0;
        bit to;
        pe_full = '0; pe_conv_done = '0;
        start_layer(MODE_CONV, 1);
        drive_layer(500, 1'b1, STAGE_CONV, 0, to);
        cm0 = n_cm; ld0 = n_ld;
        pe_conv_done = 6'b011111;
        start = 1'b1; cfg_mode = MODE_FC; cfg_rounds = 8'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (to || op_stage !== STAGE_CONV || pe_mode !== MODE_CONV) begin
                failures++; $display("FAIL busy_hold[%0d]: stage=%0d mode=%0d want %0d/%0d", i, op_stage, pe_mode, STAGE_CONV, MODE_CONV);
            end
        end
        start = 1'b0;
        drive_layer(1000, 1'b0, STAGE_IDLE, 0, to);
        checks++;
        if (to || n_cm != cm0 || n_ld - ld0 != 1) begin
            failures++; $display("FAIL busy_finish: to=%b cm=%0d ld=%0d want 0/0/1", to, n_cm-cm0, n_ld-ld0);
        end
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_multi_round();
        test_zero_rounds();
        test_error_conv();
        test_reset_in_drain();
        test_start_while_busy();
        test_random_layers();
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pe_array_ctrl
`default_nettype wire
